// File: rtl/dmem_pkg.sv
// Shared data-memory definitions for the store buffer and its forwarding logic.
// Contents: address/data widths and the store-buffer FSM state type.
package dmem_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sb_state_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match store-to-load forwarding for the store buffer.
// Ports:
//   entry_addr/entry_data : raw buffer storage, indexed by physical slot
//   head                  : slot of the oldest occupied entry
//   count                 : number of occupied entries starting at head
//   ld_addr               : load address to compare (full width)
//   hit                   : some occupied entry matches ld_addr
//   data                  : data of the youngest matching entry, 0 on miss
module sb_fwd_match
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [ADDR_W-1:0]          entry_addr [DEPTH],
    input  logic [DATA_W-1:0]          entry_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Vectors are ordered by age: element 0 is the oldest entry (at head).
    logic [PTR_W-1:0] slot_vec  [DEPTH];
    logic [DEPTH-1:0] match_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            // Pointer arithmetic wraps naturally because DEPTH is a power of two.
            assign slot_vec[gi]  = head + PTR_W'(gi);
            assign match_vec[gi] = (CNT_W'(gi) < count) &&
                                   (entry_addr[slot_vec[gi]] == ld_addr);
        end
    endgenerate

    // Scanning oldest to youngest lets the last match win, i.e. the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_vec[k]) begin
                hit  = 1'b1;
                data = entry_data[slot_vec[k]];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the core and a single-ported data memory.
// Stores are queued in a circular FIFO and drained one per cycle whenever the
// memory port is not taken by a missing load; loads are forwarded from the
// youngest matching entry. A flush request drains the buffer with priority
// over loads and signals completion with a one-cycle flush_done pulse.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   st_valid/st_addr/st_data       : store request; st_ready = accepted this edge
//   ld_valid/ld_addr               : load request
//   ld_hit/ld_data/ld_stall        : forwarding result, hold-the-load indicator
//   flush_req/flush_done           : drain request pulse / completion pulse
//   mem_rw/mem_addr/mem_wdata      : data memory port (1 = write)
//   count                          : occupied entries
module store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_stall,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     mem_rw,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    sb_state_t        state_reg;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             flush_done_reg;

    logic             nonempty;
    logic             drain_blocked;
    logic             drain;
    logic             push;

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entry_addr (addr_mem),
        .entry_data (data_mem),
        .head       (head_reg),
        .count      (count_reg),
        .ld_addr    (ld_addr),
        .hit        (ld_hit),
        .data       (ld_data)
    );

    assign nonempty = (count_reg != '0);

    // Acceptance is decided from registered state only, so a full buffer
    // refuses a store even in a cycle where an entry is being drained.
    assign st_ready = (count_reg < CNT_W'(DEPTH)) && (state_reg == RUN);
    assign push     = st_valid && st_ready && !rst;

    // In RUN a missing load owns the memory port; in FLUSH the drain does.
    assign drain_blocked = (state_reg == RUN) && ld_valid && !ld_hit;
    assign drain         = nonempty && !drain_blocked && !rst;
    assign ld_stall      = (state_reg == FLUSH) && nonempty && ld_valid && !ld_hit;

    assign mem_rw    = drain;
    assign mem_addr  = drain ? addr_mem[head_reg] : ld_addr;
    assign mem_wdata = drain ? data_mem[head_reg] : '0;

    assign count      = count_reg;
    assign flush_done = flush_done_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, drain})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Entry storage carries no reset; occupancy is defined by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= st_addr;
            data_mem[tail_reg] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            flush_done_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            flush_done_reg <= 1'b0;
            if (push)  tail_reg <= tail_reg + PTR_W'(1);
            if (drain) head_reg <= head_reg + PTR_W'(1);

            case (state_reg)
                RUN: begin
                    if (flush_req) begin
                        // Already empty after this edge: complete immediately.
                        if (count_next == '0) flush_done_reg <= 1'b1;
                        else                  state_reg      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (count_next == '0) begin
                        state_reg      <= RUN;
                        flush_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer (DEPTH=4) with hand-computed expectations.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [63:0] ld_addr;
    logic        ld_hit;
    logic [63:0] ld_data;
    logic        ld_stall;
    logic        flush_req;
    logic        flush_done;
    logic        mem_rw;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .ld_stall   (ld_stall),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .count      (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance past the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; flush_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        settle();

        // Reset state
        check("rst_st_ready", 64'(st_ready), 64'd1);
        check("rst_mem_rw", 64'(mem_rw), 64'd0);
        check("rst_ld_hit", 64'(ld_hit), 64'd0);
        check("rst_ld_stall", 64'(ld_stall), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);

        // Single store drains next cycle; draining entry still forwards
        st_valid = 1'b1; st_addr = 64'h10; st_data = 64'hAA;
        settle();
        check("s1_mem_rw_empty", 64'(mem_rw), 64'd0);
        tick();
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 64'h10;
        settle();
        check("s1_count", 64'(count), 64'd1);
        check("s1_mem_rw", 64'(mem_rw), 64'd1);
        check("s1_mem_addr", mem_addr, 64'h10);
        check("s1_mem_wdata", mem_wdata, 64'hAA);
        check("s1_fwd_hit", 64'(ld_hit), 64'd1);
        check("s1_fwd_data", ld_data, 64'hAA);
        tick();
        ld_valid = 1'b0;
        settle();
        check("s1_count_after", 64'(count), 64'd0);
        check("s1_idle_wdata", mem_wdata, 64'd0);

        // Two stores to 0x8 behind missing loads; youngest data forwarded
        ld_valid = 1'b1; ld_addr = 64'h100;
        st_valid = 1'b1; st_addr = 64'h8; st_data = 64'd1;
        tick();
        st_data = 64'd2;
        settle();
        check("s2_blocked_rw", 64'(mem_rw), 64'd0);
        check("s2_blocked_addr", mem_addr, 64'h100);
        check("s2_miss_stall", 64'(ld_stall), 64'd0);
        tick();
        st_valid = 1'b0; ld_addr = 64'h8;
        settle();
        check("s2_count", 64'(count), 64'd2);
        check("s2_hit", 64'(ld_hit), 64'd1);
        check("s2_data", ld_data, 64'd2);
        check("s2_drain_addr", mem_addr, 64'h8);
        check("s2_drain_wdata", mem_wdata, 64'd1);
        tick();
        settle();
        check("s2_hit2", 64'(ld_hit), 64'd1);
        check("s2_data2", ld_data, 64'd2);
        check("s2_drain_wdata2", mem_wdata, 64'd2);
        tick();
        settle();
        check("s2_empty", 64'(count), 64'd0);
        check("s2_empty_hit", 64'(ld_hit), 64'd0);

        // Five stores with continuous misses: fills at four, nothing written
        ld_addr = 64'h200;
        for (int k = 0; k < 5; k++) begin
            st_valid = 1'b1; st_addr = 64'h20 + 64'(8 * k); st_data = 64'h50 + 64'(k);
            settle();
            check($sformatf("s3_st_ready_%0d", k), 64'(st_ready), (k < 4) ? 64'd1 : 64'd0);
            check($sformatf("s3_mem_rw_%0d", k), 64'(mem_rw), 64'd0);
            tick();
        end
        st_valid = 1'b0;
        settle();
        check("s3_count_full", 64'(count), 64'd4);
        check("s3_miss_hit", 64'(ld_hit), 64'd0);
        check("s3_miss_data", ld_data, 64'd0);

        // Full buffer: push refused in the same cycle an entry drains
        ld_valid = 1'b0;
        st_valid = 1'b1; st_addr = 64'h40; st_data = 64'h99;
        settle();
        check("s4_st_ready", 64'(st_ready), 64'd0);
        check("s4_mem_rw", 64'(mem_rw), 64'd1);
        check("s4_mem_addr", mem_addr, 64'h20);
        tick();
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 64'h40;
        settle();
        check("s4_count", 64'(count), 64'd3);
        check("s4_refused_hit", 64'(ld_hit), 64'd0);

        // Flush three entries in FIFO order; missing load stalls
        ld_addr = 64'h300; flush_req = 1'b1;
        settle();
        check("s5_req_rw", 64'(mem_rw), 64'd0);
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            flush_req = (k == 1); // repeated request while flushing is ignored
            settle();
            check($sformatf("s5_rw_%0d", k), 64'(mem_rw), 64'd1);
            check($sformatf("s5_addr_%0d", k), mem_addr, 64'h28 + 64'(8 * k));
            check($sformatf("s5_wdata_%0d", k), mem_wdata, 64'h51 + 64'(k));
            check($sformatf("s5_st_ready_%0d", k), 64'(st_ready), 64'd0);
            check($sformatf("s5_stall_%0d", k), 64'(ld_stall), 64'd1);
            check($sformatf("s5_done_%0d", k), 64'(flush_done), 64'd0);
            tick();
        end
        flush_req = 1'b0;
        settle();
        check("s5_done", 64'(flush_done), 64'd1);
        check("s5_count", 64'(count), 64'd0);
        check("s5_st_ready_after", 64'(st_ready), 64'd1);
        check("s5_stall_after", 64'(ld_stall), 64'd0);
        check("s5_rw_after", 64'(mem_rw), 64'd0);
        tick();
        check("s5_done_pulse", 64'(flush_done), 64'd0);

        // Flush of an empty buffer completes on the next cycle
        ld_valid = 1'b0; flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        settle();
        check("s6_done", 64'(flush_done), 64'd1);
        tick();
        check("s6_done_pulse", 64'(flush_done), 64'd0);

        // Reset with three pending stores discards them
        ld_valid = 1'b1; ld_addr = 64'h700;
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1; st_addr = 64'h60 + 64'(8 * k); st_data = 64'hC0 + 64'(k);
            tick();
        end
        st_valid = 1'b0;
        check("s7_count", 64'(count), 64'd3);
        ld_valid = 1'b0; rst = 1'b1;
        settle();
        check("s7_rst_rw", 64'(mem_rw), 64'd0);
        tick();
        rst = 1'b0; ld_valid = 1'b1; ld_addr = 64'h60;
        settle();
        check("s7_count_rst", 64'(count), 64'd0);
        check("s7_hit", 64'(ld_hit), 64'd0);
        check("s7_data", ld_data, 64'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("s7_rw_%0d", k), 64'(mem_rw), 64'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
